// File: rtl/dispatch_buffer_pkg.sv
// Shared types, unit tags and op-class codes for the dispatch queue.
package dispatch_buffer_pkg;

  localparam int DB_XLEN  = 32;
  localparam int DB_AW    = 32;
  localparam int DB_TAG_W = 3;
  localparam int DB_NALU  = 2;

  typedef logic [7:0]          oper_t;
  typedef logic [DB_AW-1:0]    addr_t;
  typedef logic [DB_XLEN-1:0]  word_t;
  typedef logic [DB_TAG_W-1:0] regtag_t;
  typedef logic [4:0]          regaddr_t;

  localparam regtag_t UNLOCKED   = '0;
  localparam regtag_t TAG_LS     = regtag_t'(DB_NALU + 1);
  localparam regtag_t TAG_BRANCH = regtag_t'(DB_NALU + 2);

  localparam logic [3:0] CLS_ALU_A  = 4'b0001;
  localparam logic [3:0] CLS_ALU_B  = 4'b0010;
  localparam logic [3:0] CLS_ALU_C  = 4'b0101;
  localparam logic [3:0] CLS_ALU_D  = 4'b1101;
  localparam logic [3:0] CLS_STORE  = 4'b0011;
  localparam logic [3:0] CLS_LOAD   = 4'b1001;
  localparam logic [3:0] CLS_BRANCH = 4'b0100;

  typedef enum logic [2:0] {K_NOP, K_ALU, K_LOAD, K_STORE, K_BRANCH} kind_t;

  function automatic kind_t op_kind(input logic [3:0] cls);
    case (cls)
      CLS_ALU_A, CLS_ALU_B, CLS_ALU_C, CLS_ALU_D: op_kind = K_ALU;
      CLS_LOAD:   op_kind = K_LOAD;
      CLS_STORE:  op_kind = K_STORE;
      CLS_BRANCH: op_kind = K_BRANCH;
      default:    op_kind = K_NOP;
    endcase
  endfunction

endpackage

// File: rtl/dispatch_wakeup.sv
// Combinational CDB snoop: replaces a locked operand with the matching writeback result.
// Zero latency, no backpressure; lowest-numbered matching port wins.
module dispatch_wakeup #(
  parameter int XLEN     = 32,
  parameter int TAG_W    = 3,
  parameter int NWB      = 3,
  parameter bit TAG_ONLY = 1'b0
) (
  input  logic [XLEN-1:0]      data_in,
  input  logic [TAG_W-1:0]     tag_in,
  input  logic [NWB-1:0]       wb_en,
  input  logic [NWB*TAG_W-1:0] wb_tag,
  input  logic [NWB*XLEN-1:0]  wb_data,
  output logic [XLEN-1:0]      data_out,
  output logic [TAG_W-1:0]     tag_out
);

  always_comb begin
    data_out = data_in;
    tag_out  = tag_in;
    // Walk from the top so the lowest matching port is applied last.
    for (int k = NWB - 1; k >= 0; k--) begin
      if (wb_en[k] && (tag_in != '0) && (wb_tag[k*TAG_W +: TAG_W] == tag_in)) begin
        tag_out = '0;
        if (!TAG_ONLY) data_out = wb_data[k*XLEN +: XLEN];
      end
    end
  end

endmodule

// File: rtl/dispatch_buffer.sv
// In-order dispatch queue with CDB wakeup; one issue per cycle from the head, registered (enqueue-to-issue >= 2 cycles).
// Backpressure: in_ready drops when full or flushing; a blocked head stalls the whole queue.
module dispatch_buffer
  import dispatch_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int NALU  = DB_NALU,
  parameter int NWB   = 3,
  parameter int XLEN  = DB_XLEN,
  parameter int AW    = DB_AW,
  parameter int TAG_W = DB_TAG_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  oper_t                    in_op,
  input  logic [AW-1:0]            in_pc,
  input  logic [XLEN-1:0]          in_imm,
  input  logic [XLEN-1:0]          in_datax,
  input  logic [XLEN-1:0]          in_datay,
  input  logic [TAG_W-1:0]         in_tagx,
  input  logic [TAG_W-1:0]         in_tagy,
  input  logic [TAG_W-1:0]         in_tagw,
  input  regaddr_t                 in_addrw,
  input  logic [NWB-1:0]           wb_en,
  input  logic [NWB*TAG_W-1:0]     wb_tag,
  input  logic [NWB*XLEN-1:0]      wb_data,
  input  logic [NALU+1:0]          unit_busy,
  output logic [NALU+1:0]          iss_en,
  output logic [3:0]               iss_op,
  output logic [AW-1:0]            iss_pc,
  output logic [XLEN-1:0]          iss_imm,
  output logic [XLEN-1:0]          iss_datax,
  output logic [XLEN-1:0]          iss_datay,
  output logic [TAG_W-1:0]         iss_tagx,
  output logic [TAG_W-1:0]         iss_tagy,
  output logic [TAG_W-1:0]         iss_tagw,
  output regaddr_t                 iss_addrw,
  output logic                     ren_en,
  output regaddr_t                 ren_addr,
  output logic [TAG_W-1:0]         ren_tag,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int NU = NALU + 2;

  oper_t            q_op  [DEPTH];
  logic [AW-1:0]    q_pc  [DEPTH];
  logic [XLEN-1:0]  q_imm [DEPTH];
  logic [XLEN-1:0]  q_dx  [DEPTH];
  logic [XLEN-1:0]  q_dy  [DEPTH];
  logic [TAG_W-1:0] q_tx  [DEPTH];
  logic [TAG_W-1:0] q_ty  [DEPTH];
  logic [TAG_W-1:0] q_tw  [DEPTH];
  regaddr_t         q_aw  [DEPTH];

  logic [XLEN-1:0]  w_dx [DEPTH];
  logic [XLEN-1:0]  w_dy [DEPTH];
  logic [TAG_W-1:0] w_tx [DEPTH];
  logic [TAG_W-1:0] w_ty [DEPTH];
  logic [TAG_W-1:0] w_tw [DEPTH];
  logic [XLEN-1:0]  unused_wdat [DEPTH+1];

  logic [XLEN-1:0]  in_dx_w, in_dy_w;
  logic [TAG_W-1:0] in_tx_w, in_ty_w, in_tw_w;

  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count_q;

  for (genvar e = 0; e < DEPTH; e++) begin : g_ent
    dispatch_wakeup #(.XLEN(XLEN), .TAG_W(TAG_W), .NWB(NWB)) u_wx (
      .data_in(q_dx[e]), .tag_in(q_tx[e]), .wb_en(wb_en), .wb_tag(wb_tag), .wb_data(wb_data),
      .data_out(w_dx[e]), .tag_out(w_tx[e]));
    dispatch_wakeup #(.XLEN(XLEN), .TAG_W(TAG_W), .NWB(NWB)) u_wy (
      .data_in(q_dy[e]), .tag_in(q_ty[e]), .wb_en(wb_en), .wb_tag(wb_tag), .wb_data(wb_data),
      .data_out(w_dy[e]), .tag_out(w_ty[e]));
    dispatch_wakeup #(.XLEN(XLEN), .TAG_W(TAG_W), .NWB(NWB), .TAG_ONLY(1'b1)) u_ww (
      .data_in('0), .tag_in(q_tw[e]), .wb_en(wb_en), .wb_tag(wb_tag), .wb_data(wb_data),
      .data_out(unused_wdat[e]), .tag_out(w_tw[e]));
  end

  dispatch_wakeup #(.XLEN(XLEN), .TAG_W(TAG_W), .NWB(NWB)) u_in_wx (
    .data_in(in_datax), .tag_in(in_tagx), .wb_en(wb_en), .wb_tag(wb_tag), .wb_data(wb_data),
    .data_out(in_dx_w), .tag_out(in_tx_w));
  dispatch_wakeup #(.XLEN(XLEN), .TAG_W(TAG_W), .NWB(NWB)) u_in_wy (
    .data_in(in_datay), .tag_in(in_tagy), .wb_en(wb_en), .wb_tag(wb_tag), .wb_data(wb_data),
    .data_out(in_dy_w), .tag_out(in_ty_w));
  dispatch_wakeup #(.XLEN(XLEN), .TAG_W(TAG_W), .NWB(NWB), .TAG_ONLY(1'b1)) u_in_ww (
    .data_in('0), .tag_in(in_tagw), .wb_en(wb_en), .wb_tag(wb_tag), .wb_data(wb_data),
    .data_out(unused_wdat[DEPTH]), .tag_out(in_tw_w));

  // Head view already carries this cycle's wakeup.
  oper_t          h_op;
  kind_t          h_kind;
  logic           head_vld, push, pop, do_iss;
  logic [NU-1:0]  free_u, sel;
  logic [TAG_W-1:0] sel_tag;

  assign h_op     = q_op[rd_ptr];
  assign h_kind   = op_kind(h_op[7:4]);
  assign head_vld = (count_q != '0);
  assign in_ready = (count_q < CW'(DEPTH)) && !flush;
  assign push     = in_valid && in_ready;
  assign count    = count_q;

  // A unit issued last cycle is treated as busy for one more cycle.
  assign free_u = ~unit_busy & ~iss_en;

  always_comb begin
    sel     = '0;
    sel_tag = '0;
    case (h_kind)
      K_ALU: begin
        for (int i = NALU - 1; i >= 0; i--) begin
          if (free_u[i]) begin
            sel     = '0;
            sel[i]  = 1'b1;
            sel_tag = TAG_W'(i + 1);
          end
        end
      end
      K_LOAD, K_STORE: begin
        sel[NALU] = free_u[NALU];
        sel_tag   = TAG_W'(NALU + 1);
      end
      K_BRANCH: sel[NALU+1] = free_u[NALU+1];
      default: ;
    endcase
  end

  assign do_iss = head_vld && !flush && (|sel);
  assign pop    = head_vld && !flush && ((h_kind == K_NOP) || (|sel));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int e = 0; e < DEPTH; e++) begin
        q_op[e] <= '0; q_pc[e] <= '0; q_imm[e] <= '0;
        q_dx[e] <= '0; q_dy[e] <= '0;
        q_tx[e] <= '0; q_ty[e] <= '0; q_tw[e] <= '0; q_aw[e] <= '0;
      end
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      for (int e = 0; e < DEPTH; e++) begin
        q_dx[e] <= w_dx[e]; q_tx[e] <= w_tx[e];
        q_dy[e] <= w_dy[e]; q_ty[e] <= w_ty[e];
        q_tw[e] <= w_tw[e];
      end
      if (push) begin
        q_op[wr_ptr]  <= in_op;
        q_pc[wr_ptr]  <= in_pc;
        q_imm[wr_ptr] <= in_imm;
        q_dx[wr_ptr]  <= in_dx_w;
        q_tx[wr_ptr]  <= in_tx_w;
        q_dy[wr_ptr]  <= in_dy_w;
        q_ty[wr_ptr]  <= in_ty_w;
        q_tw[wr_ptr]  <= in_tw_w;
        q_aw[wr_ptr]  <= in_addrw;
        wr_ptr        <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      iss_en    <= '0; iss_op    <= '0; iss_pc    <= '0; iss_imm  <= '0;
      iss_datax <= '0; iss_datay <= '0; iss_tagx  <= '0; iss_tagy <= '0;
      iss_tagw  <= '0; iss_addrw <= '0;
      ren_en    <= 1'b0; ren_addr <= '0; ren_tag <= '0;
    end else begin
      iss_en <= do_iss ? sel : '0;
      ren_en <= do_iss && ((h_kind == K_ALU) || (h_kind == K_LOAD));
      if (do_iss) begin
        iss_op    <= h_op[3:0];
        iss_pc    <= q_pc[rd_ptr];
        iss_imm   <= q_imm[rd_ptr];
        iss_datax <= w_dx[rd_ptr];
        iss_datay <= w_dy[rd_ptr];
        iss_tagx  <= w_tx[rd_ptr];
        iss_tagy  <= w_ty[rd_ptr];
        iss_tagw  <= (h_kind == K_STORE) ? '0 : w_tw[rd_ptr];
        iss_addrw <= q_aw[rd_ptr];
        if ((h_kind == K_ALU) || (h_kind == K_LOAD)) begin
          ren_addr <= q_aw[rd_ptr];
          ren_tag  <= sel_tag;
        end
      end
    end
  end

endmodule

// File: tb/tb_dispatch_buffer.sv
// Directed bench for dispatch_buffer: queue-level reference model compared every cycle, plus literal spot checks.
module tb_dispatch_buffer;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready;
  logic [7:0]  in_op;
  logic [31:0] in_pc, in_imm, in_datax, in_datay;
  logic [2:0]  in_tagx, in_tagy, in_tagw;
  logic [4:0]  in_addrw;
  logic [2:0]  wb_en;
  logic [8:0]  wb_tag;
  logic [95:0] wb_data;
  logic [3:0]  unit_busy, iss_en;
  logic [3:0]  iss_op;
  logic [31:0] iss_pc, iss_imm, iss_datax, iss_datay;
  logic [2:0]  iss_tagx, iss_tagy, iss_tagw, ren_tag;
  logic [4:0]  iss_addrw, ren_addr;
  logic        ren_en;
  logic [2:0]  count;

  dispatch_buffer dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_pc(in_pc), .in_imm(in_imm), .in_datax(in_datax), .in_datay(in_datay),
    .in_tagx(in_tagx), .in_tagy(in_tagy), .in_tagw(in_tagw), .in_addrw(in_addrw),
    .wb_en(wb_en), .wb_tag(wb_tag), .wb_data(wb_data), .unit_busy(unit_busy),
    .iss_en(iss_en), .iss_op(iss_op), .iss_pc(iss_pc), .iss_imm(iss_imm),
    .iss_datax(iss_datax), .iss_datay(iss_datay), .iss_tagx(iss_tagx), .iss_tagy(iss_tagy),
    .iss_tagw(iss_tagw), .iss_addrw(iss_addrw), .ren_en(ren_en), .ren_addr(ren_addr),
    .ren_tag(ren_tag), .count(count));

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic [7:0]  op;
    logic [31:0] pc, imm, dx, dy;
    logic [2:0]  tx, ty, tw;
    logic [4:0]  aw;
  } ent_t;

  ent_t        mq[$];
  logic [3:0]  m_iss_en;
  logic        m_ren_en, m_push;
  logic [3:0]  m_op;
  logic [31:0] m_pc, m_imm, m_dx, m_dy;
  logic [2:0]  m_tx, m_ty, m_tw, m_rtag;
  logic [4:0]  m_aw, m_raddr;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [34:0] wake(input logic [31:0] d, input logic [2:0] t);
    if (t != 3'd0)
      for (int k = 0; k < 3; k++)
        if (wb_en[k] && wb_tag[k*3 +: 3] == t) return {wb_data[k*32 +: 32], 3'd0};
    return {d, t};
  endfunction

  function automatic logic [2:0] wake_tag(input logic [2:0] t);
    logic [34:0] r;
    r = wake(32'd0, t);
    return r[2:0];
  endfunction

  task automatic model_reset();
    mq.delete();
    m_iss_en = '0; m_ren_en = 1'b0; m_push = 1'b0;
    m_op = '0; m_pc = '0; m_imm = '0; m_dx = '0; m_dy = '0;
    m_tx = '0; m_ty = '0; m_tw = '0; m_aw = '0; m_raddr = '0; m_rtag = '0;
  endtask

  // Predicts the outputs after the coming clock edge from the current inputs.
  task automatic model_step();
    ent_t e, h;
    int u;
    bit full, is_nop, is_ren;
    logic [3:0] new_en;
    m_push = 1'b0;
    if (flush) begin
      mq.delete();
      m_iss_en = '0;
      m_ren_en = 1'b0;
      return;
    end
    full = (mq.size() >= 4);
    foreach (mq[i]) begin
      e = mq[i];
      {e.dx, e.tx} = wake(e.dx, e.tx);
      {e.dy, e.ty} = wake(e.dy, e.ty);
      e.tw = wake_tag(e.tw);
      mq[i] = e;
    end
    new_en = '0;
    is_ren = 1'b0;
    if (mq.size() > 0) begin
      h = mq[0];
      u = -1;
      is_nop = 1'b0;
      case (h.op[7:4])
        4'd1, 4'd2, 4'd5, 4'd13: begin
          for (int i = 0; i < 2; i++)
            if (u < 0 && !unit_busy[i] && !m_iss_en[i]) u = i;
          is_ren = 1'b1;
        end
        4'd3: if (!unit_busy[2] && !m_iss_en[2]) u = 2;
        4'd9: begin
          if (!unit_busy[2] && !m_iss_en[2]) u = 2;
          is_ren = 1'b1;
        end
        4'd4: if (!unit_busy[3] && !m_iss_en[3]) u = 3;
        default: is_nop = 1'b1;
      endcase
      if (is_nop) begin
        void'(mq.pop_front());
        is_ren = 1'b0;
      end else if (u >= 0) begin
        void'(mq.pop_front());
        new_en[u] = 1'b1;
        m_op = h.op[3:0]; m_pc = h.pc; m_imm = h.imm;
        m_dx = h.dx; m_dy = h.dy; m_tx = h.tx; m_ty = h.ty;
        m_tw = (h.op[7:4] == 4'd3) ? 3'd0 : h.tw;
        m_aw = h.aw;
        if (is_ren) begin
          m_raddr = h.aw;
          m_rtag  = 3'(u + 1);
        end
      end else begin
        is_ren = 1'b0;
      end
    end
    if (in_valid && !full) begin
      e.op = in_op; e.pc = in_pc; e.imm = in_imm; e.aw = in_addrw;
      {e.dx, e.tx} = wake(in_datax, in_tagx);
      {e.dy, e.ty} = wake(in_datay, in_tagy);
      e.tw = wake_tag(in_tagw);
      mq.push_back(e);
      m_push = 1'b1;
    end
    m_iss_en = new_en;
    m_ren_en = is_ren && (new_en != 4'd0);
  endtask

  task automatic step();
    #1;
    chk("in_ready", in_ready, (mq.size() < 4) && !flush);
    model_step();
    @(posedge clk);
    #1;
    chk("count", count, mq.size());
    chk("iss_en", iss_en, m_iss_en);
    chk("ren_en", ren_en, m_ren_en);
    chk("iss_op", iss_op, m_op);
    chk("iss_pc", iss_pc, m_pc);
    chk("iss_imm", iss_imm, m_imm);
    chk("iss_datax", iss_datax, m_dx);
    chk("iss_datay", iss_datay, m_dy);
    chk("iss_tagx", iss_tagx, m_tx);
    chk("iss_tagy", iss_tagy, m_ty);
    chk("iss_tagw", iss_tagw, m_tw);
    chk("iss_addrw", iss_addrw, m_aw);
    chk("ren_addr", ren_addr, m_raddr);
    chk("ren_tag", ren_tag, m_rtag);
  endtask

  task automatic set_op(input logic [7:0] op, input logic [31:0] pc, input logic [31:0] dx,
                        input logic [31:0] dy, input logic [2:0] tx, input logic [2:0] ty,
                        input logic [2:0] tw, input logic [4:0] aw);
    in_valid = 1'b1; in_op = op; in_pc = pc; in_imm = pc ^ 32'h55;
    in_datax = dx; in_datay = dy; in_tagx = tx; in_tagy = ty; in_tagw = tw; in_addrw = aw;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic run_until_issue(input int max_cyc, input string nm);
    bit got = 1'b0;
    for (int i = 0; i < max_cyc && !got; i++) begin
      step();
      if (iss_en != 4'd0) got = 1'b1;
    end
    n_chk++;
    if (!got) begin
      n_err++;
      $display("FAIL %s: no issue within %0d cycles", nm, max_cyc);
    end
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; unit_busy = '0;
    in_valid = 1'b0; in_op = '0; in_pc = '0; in_imm = '0; in_datax = '0; in_datay = '0;
    in_tagx = '0; in_tagy = '0; in_tagw = '0; in_addrw = '0;
    wb_en = '0; wb_tag = '0; wb_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset count", count, 0);
    chk("reset iss_en", iss_en, 0);
    chk("reset ren_en", ren_en, 0);
    chk("reset iss_pc", iss_pc, 0);
    rst = 1'b1;
    #1;
    chk("reset in_ready", in_ready, 1);

    // 1: single ALU op, two-cycle latency, then a no-op that must be dropped.
    set_op(8'h15, 32'h100, 32'd11, 32'd22, 3'd0, 3'd0, 3'd0, 5'd3);
    step();
    idle();
    step();
    chk("t1 iss_en", iss_en, 4'b0001);
    chk("t1 ren_tag", ren_tag, 3'd1);
    chk("t1 ren_addr", ren_addr, 5'd3);
    chk("t1 iss_datax", iss_datax, 32'd11);
    step();
    chk("t1 single pulse", iss_en, 4'b0000);
    set_op(8'h07, 32'h104, 32'd1, 32'd2, 3'd0, 3'd0, 3'd0, 5'd4);
    step();
    set_op(8'h23, 32'h108, 32'd5, 32'd6, 3'd0, 3'd0, 3'd0, 5'd5);
    step();
    idle();
    repeat (3) step();

    // 2: back-to-back ALU ops spread across both ALUs.
    set_op(8'h51, 32'h200, 32'hA, 32'hB, 3'd0, 3'd0, 3'd0, 5'd6);
    step();
    set_op(8'hD2, 32'h204, 32'hC, 32'hD, 3'd0, 3'd0, 3'd0, 5'd7);
    step();
    chk("t2 first alu", iss_en, 4'b0001);
    idle();
    step();
    chk("t2 second alu", iss_en, 4'b0010);
    chk("t2 ren_tag", ren_tag, 3'd2);
    step();

    // 3: load waits on LS while its operands wake from the CDB.
    unit_busy = 4'b0100;
    set_op(8'h90, 32'h300, 32'h0, 32'h0, 3'd3, 3'd2, 3'd0, 5'd8);
    step();
    idle();
    step();
    wb_en = 3'b111;
    wb_tag = {3'd3, 3'd2, 3'd2};
    wb_data = {32'hDEADBEEF, 32'h22222222, 32'h11111111};
    step();
    wb_en = '0;
    unit_busy = '0;
    step();
    chk("t3 iss_en", iss_en, 4'b0100);
    chk("t3 iss_datax", iss_datax, 32'hDEADBEEF);
    chk("t3 iss_tagx", iss_tagx, 3'd0);
    chk("t3 lowest port", iss_datay, 32'h11111111);
    chk("t3 ren_tag", ren_tag, 3'd3);
    step();

    // 4: fill with branches, pointer wrap, full blocks enqueue even while popping.
    unit_busy = 4'b1000;
    for (int i = 0; i < 4; i++) begin
      set_op(8'h40 + 8'(i), 32'h400 + 32'(i * 4), 32'd0, 32'd0, 3'd0, 3'd0, 3'd0, 5'd0);
      step();
    end
    chk("t4 count full", count, 3'd4);
    set_op(8'h44, 32'h410, 32'd0, 32'd0, 3'd0, 3'd0, 3'd0, 5'd0);
    #1;
    chk("t4 in_ready full", in_ready, 1'b0);
    step();
    unit_busy = '0;
    step();
    chk("t4 first pop", iss_en, 4'b1000);
    chk("t4 no enqueue when full", count, 3'd3);
    step();
    chk("t4 fifth accepted", count, 3'd4);
    idle();
    for (int i = 0; i < 16 && mq.size() > 0; i++) step();
    chk("t4 drained", count, 3'd0);
    step();

    // 5: store forces tagw 0 without rename; load renames to the LS tag.
    set_op(8'h31, 32'h500, 32'h7, 32'h8, 3'd0, 3'd0, 3'd2, 5'd7);
    step();
    set_op(8'h92, 32'h504, 32'h9, 32'hA, 3'd0, 3'd0, 3'd1, 5'd9);
    step();
    chk("t5 store iss_en", iss_en, 4'b0100);
    chk("t5 store tagw", iss_tagw, 3'd0);
    chk("t5 store ren_en", ren_en, 1'b0);
    idle();
    run_until_issue(5, "t5 load issue");
    chk("t5 load tagw", iss_tagw, 3'd1);
    chk("t5 load ren_en", ren_en, 1'b1);
    chk("t5 load ren_tag", ren_tag, 3'd3);
    chk("t5 load ren_addr", ren_addr, 5'd9);

    // 6: flush with an op offered clears the queue and ignores the op.
    unit_busy = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      set_op(8'h10, 32'h600 + 32'(i * 4), 32'd0, 32'd0, 3'd0, 3'd0, 3'd0, 5'(i));
      step();
    end
    chk("t6 queued", count, 3'd3);
    flush = 1'b1;
    set_op(8'h10, 32'h610, 32'd0, 32'd0, 3'd0, 3'd0, 3'd0, 5'd10);
    step();
    chk("t6 flushed count", count, 3'd0);
    chk("t6 flushed iss_en", iss_en, 4'b0000);
    flush = 1'b0;
    set_op(8'h10, 32'h614, 32'h33, 32'd0, 3'd0, 3'd0, 3'd0, 5'd11);
    step();
    chk("t6 accept after flush", count, 3'd1);
    idle();
    unit_busy = '0;
    run_until_issue(4, "t6 post-flush issue");
    chk("t6 post-flush pc", iss_pc, 32'h614);

    // 7: asynchronous reset mid-operation.
    unit_busy = 4'b1111;
    set_op(8'h10, 32'h700, 32'd0, 32'd0, 3'd0, 3'd0, 3'd0, 5'd1);
    step();
    step();
    idle();
    rst = 1'b0;
    #2;
    chk("t7 async count", count, 3'd0);
    chk("t7 async iss_pc", iss_pc, 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    unit_busy = '0;
    step();
    step();
    chk("t7 no strobe", iss_en, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
